alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/toyrisc_pkg.sv | 35 +++
 rtl/regfile16x32.sv | 40 ++++
 rtl/alu_issue.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/toyrisc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : toyrisc_pkg
// Description : Shared definitions for the toy RISC issue stage. Covers the
//               instruction field layout, the issue FSM state encoding, the
//               register file size and an immediate sign-extension helper.
// Revision    : 1.0 - initial release
// ============================================================================
package toyrisc_pkg;

    localparam int NREGS       = 16;
    localparam int REG_W       = 4;
    localparam int FUNC_W      = 4;
    localparam int IMM_W       = 15;
    localparam int XLEN        = 32;

    localparam int FUNC_LSB    = 28;
    localparam int RD_LSB      = 24;
    localparam int RS1_LSB     = 20;
    localparam int RS2_LSB     = 16;
    localparam int USE_IMM_BIT = 15;
    localparam int IMM_LSB     = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    function automatic logic [XLEN-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile16x32.sv
`default_nettype none
// ============================================================================
// Module      : regfile16x32
// Description : 16 x 32 architectural register file with two combinational
//               read ports and one write port. r0 always reads zero and
//               writes to it are dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile16x32
    import toyrisc_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [REG_W-1:0]      waddr,
    input  logic [XLEN-1:0]       wdata,
    input  logic [REG_W-1:0]      raddr1,
    input  logic [REG_W-1:0]      raddr2,
    output logic [XLEN-1:0]       rdata1,
    output logic [XLEN-1:0]       rdata2
);

    logic [XLEN-1:0] regs [NREGS];

    // Storage: cleared on reset, r0 never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue
// Description : Single-issue front end for an external ALU. Decodes an
//               instruction, reads operands (with writeback forwarding),
//               waits ALU_LAT cycles, then strobes the result for one cycle
//               and retires it into the register file.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue #(
    parameter int ALU_LAT = 1,
    parameter int NREGS   = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        instrValid,
    output logic        instrReady,
    input  logic [31:0] instr,
    output logic [31:0] leftOp,
    output logic [31:0] rightOp,
    output logic [3:0]  funcOut,
    input  logic [31:0] aluResult,
    output logic        wbValid,
    output logic [3:0]  wbReg,
    output logic [31:0] wbData,
    output logic        busy
);

    import toyrisc_pkg::*;

    localparam int CNT_W = 3;

    if ((ALU_LAT < 1) || (ALU_LAT > 7) || (NREGS != toyrisc_pkg::NREGS)) begin : g_param_check
        $error("alu_issue: unsupported ALU_LAT or NREGS");
    end

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [REG_W-1:0]   rd_q;

    logic [FUNC_W-1:0]  dec_func;
    logic [REG_W-1:0]   dec_rd;
    logic [REG_W-1:0]   dec_rs1;
    logic [REG_W-1:0]   dec_rs2;
    logic               dec_use_imm;
    logic [XLEN-1:0]    dec_imm;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    logic               fwd1;
    logic               fwd2;
    logic [XLEN-1:0]    op_a;
    logic [XLEN-1:0]    op_b;
    logic               accept;
    logic               rf_we;

    assign dec_func    = instr[FUNC_LSB +: FUNC_W];
    assign dec_rd      = instr[RD_LSB   +: REG_W];
    assign dec_rs1     = instr[RS1_LSB  +: REG_W];
    assign dec_rs2     = instr[RS2_LSB  +: REG_W];
    assign dec_use_imm = instr[USE_IMM_BIT];
    assign dec_imm     = sext_imm(instr[IMM_LSB +: IMM_W]);

    // The retiring result is not yet in the register file during WB, so an
    // instruction accepted there takes it straight from wbData. r0 is never
    // forwarded because it always reads zero.
    assign fwd1 = (state == ST_WB) && (wbReg != '0) && (dec_rs1 == wbReg);
    assign fwd2 = (state == ST_WB) && (wbReg != '0) && (dec_rs2 == wbReg);

    assign op_a = fwd1 ? wbData : rs1_data;
    assign op_b = dec_use_imm ? dec_imm : (fwd2 ? wbData : rs2_data);

    // instrReady is registered and only ever high outside EXEC
    assign accept = instrValid && instrReady;
    assign rf_we  = (state == ST_WB);

    regfile16x32 u_regfile (
        .clk    (clock),
        .rst_n  (reset_n),
        .we     (rf_we),
        .waddr  (wbReg),
        .wdata  (wbData),
        .raddr1 (dec_rs1),
        .raddr2 (dec_rs2),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

    // Issue FSM with registered operand, writeback and handshake outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            rd_q       <= '0;
            leftOp     <= '0;
            rightOp    <= '0;
            funcOut    <= '0;
            wbReg      <= '0;
            wbData     <= '0;
            wbValid    <= 1'b0;
            busy       <= 1'b0;
            instrReady <= 1'b0;
        end else begin
            wbValid <= 1'b0;
            case (state)
                ST_IDLE, ST_WB: begin
                    if (accept) begin
                        leftOp     <= op_a;
                        rightOp    <= op_b;
                        funcOut    <= dec_func;
                        rd_q       <= dec_rd;
                        cnt        <= CNT_W'(ALU_LAT);
                        state      <= ST_EXEC;
                        busy       <= 1'b1;
                        instrReady <= 1'b0;
                    end else begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        instrReady <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        wbData     <= aluResult;
                        wbReg      <= rd_q;
                        wbValid    <= 1'b1;
                        state      <= ST_WB;
                        instrReady <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                    instrReady <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
